// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_unit_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_MEM,
    S_PREDICT,
    S_ISSUE,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/fetch_unit_predecode.sv
// Combinational pre-decode: control-flow class and sign-extended B/J immediates.
module if_predecode
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] ins,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_j
);
  assign is_branch = (ins[6:0] == OP_BRANCH);
  assign is_jal    = (ins[6:0] == OP_JAL);
  assign is_jalr   = (ins[6:0] == OP_JALR);
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
endmodule

// File: rtl/fetch_unit.sv
// Fetch FSM: icache request, pre-decode, predictor query, issue handshake, flush redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic            icache_req,
  output logic [XLEN-1:0] icache_addr,
  input  logic            icache_valid,
  input  logic [XLEN-1:0] icache_ins,
  output logic            ask_predictor,
  output logic [XLEN-1:0] jump_addr_from_if,
  output logic [XLEN-1:0] next_addr_from_if,
  output logic            now_ins_jalr,
  input  logic            jump,
  input  logic            predictor_sgn_rdy,
  input  logic            predictor_occupied,
  input  logic            if_flush,
  input  logic [XLEN-1:0] addr_to_if,
  output logic            ins_valid,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] ins_pc,
  output logic            ins_pred_jump,
  input  logic            issue_stall
);
  state_e            state, state_n;
  logic [XLEN-1:0]   pc, npc, ins_q;
  logic [XLEN-1:0]   pd_in, imm_b, imm_j;
  logic              is_branch, is_jal, is_jalr;

  // Classify the arriving word in WAIT_MEM, the latched word afterwards.
  assign pd_in = (state == S_WAIT_MEM) ? icache_ins : ins_q;

  if_predecode u_pd (
    .ins       (pd_in),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .imm_b     (imm_b),
    .imm_j     (imm_j)
  );

  assign ask_predictor     = (state == S_PREDICT) && (is_jalr || !predictor_occupied);
  assign now_ins_jalr      = ask_predictor && is_jalr;
  assign jump_addr_from_if = (ask_predictor && !is_jalr) ? pc + imm_b : '0;
  assign next_addr_from_if = ask_predictor ? pc + 32'd4 : '0;
  assign ins               = ins_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= S_FETCH;
    else if (rdy) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    state_n = S_WAIT_MEM;
      S_WAIT_MEM: if (icache_valid) state_n = (is_branch || is_jalr) ? S_PREDICT : S_ISSUE;
      S_PREDICT:  if (ask_predictor && predictor_sgn_rdy) state_n = S_ISSUE;
      S_ISSUE:    if (!issue_stall) state_n = S_FETCH;
      S_DRAIN:    if (icache_valid) state_n = S_FETCH;
      default:    state_n = S_FETCH;
    endcase
    // A flush overrides everything except an in-progress drain, which already owns the cache.
    if (if_flush && state != S_DRAIN)
      state_n = (state == S_WAIT_MEM && !icache_valid) ? S_DRAIN : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      npc           <= '0;
      ins_q         <= '0;
      ins_pc        <= '0;
      ins_pred_jump <= 1'b0;
      ins_valid     <= 1'b0;
      icache_req    <= 1'b0;
      icache_addr   <= '0;
    end else if (rdy) begin
      if (if_flush) begin
        pc        <= addr_to_if;
        ins_valid <= 1'b0;
        if (icache_valid) icache_req <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            icache_req  <= 1'b1;
            icache_addr <= pc;
          end
          S_WAIT_MEM: if (icache_valid) begin
            icache_req <= 1'b0;
            ins_q      <= icache_ins;
            ins_pc     <= pc;
            if (!is_branch && !is_jalr) begin
              ins_valid     <= 1'b1;
              ins_pred_jump <= is_jal;
              npc           <= is_jal ? pc + imm_j : pc + 32'd4;
            end
          end
          S_PREDICT: if (ask_predictor && predictor_sgn_rdy) begin
            ins_valid     <= 1'b1;
            ins_pred_jump <= jump;
            npc           <= jump ? jump_addr_from_if : pc + 32'd4;
          end
          S_ISSUE: if (!issue_stall) begin
            ins_valid <= 1'b0;
            pc        <= npc;
          end
          S_DRAIN: if (icache_valid) icache_req <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jal/jalr, flush/drain, stall with rdy gaps.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        icache_req, icache_valid;
  logic [31:0] icache_addr, icache_ins;
  logic        ask_predictor, now_ins_jalr, jump, predictor_sgn_rdy, predictor_occupied;
  logic [31:0] jump_addr_from_if, next_addr_from_if;
  logic        if_flush;
  logic [31:0] addr_to_if;
  logic        ins_valid, ins_pred_jump, issue_stall;
  logic [31:0] ins, ins_pc;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] BEQ16 = 32'h0000_0863;
  localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
  localparam logic [31:0] JALR  = 32'h0000_8067;

  int n_vec = 0, n_err = 0;
  int iss_cnt = 0, ask_cnt = 0, c0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_valid(icache_valid), .icache_ins(icache_ins),
    .ask_predictor(ask_predictor), .jump_addr_from_if(jump_addr_from_if),
    .next_addr_from_if(next_addr_from_if), .now_ins_jalr(now_ins_jalr),
    .jump(jump), .predictor_sgn_rdy(predictor_sgn_rdy),
    .predictor_occupied(predictor_occupied),
    .if_flush(if_flush), .addr_to_if(addr_to_if),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc),
    .ins_pred_jump(ins_pred_jump), .issue_stall(issue_stall)
  );

  always @(posedge clk) if (rst && rdy && ins_valid && !issue_stall) iss_cnt++;
  always @(negedge clk) if (ask_predictor) ask_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!icache_req && n < 20) begin cyc(); n++; end
    chk({tag, "_req"}, 32'(icache_req), 1);
    chk(tag, icache_addr, exp);
  endtask

  // Answer the outstanding request with one valid pulse.
  task automatic serve(input logic [31:0] word);
    icache_valid = 1'b1; icache_ins = word;
    cyc();
    icache_valid = 1'b0; icache_ins = '0;
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; icache_valid = 0; icache_ins = '0; jump = 0;
    predictor_sgn_rdy = 0; predictor_occupied = 0; if_flush = 0; addr_to_if = '0;
    issue_stall = 0;
    #12;
    chk("rst_req", 32'(icache_req), 0);
    chk("rst_addr", icache_addr, 0);
    chk("rst_valid", 32'(ins_valid), 0);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_ask", 32'(ask_predictor), 0);
    rst = 1'b1;

    // sequential fetch
    wait_req("fetch0", 32'h100);
    serve(ADDI);
    chk("addi_valid", 32'(ins_valid), 1);
    chk("addi_pc", ins_pc, 32'h100);
    chk("addi_ins", ins, ADDI);
    chk("addi_pj", 32'(ins_pred_jump), 0);
    wait_req("fetch1", 32'h104);

    // flush coinciding with an issue handshake: redirect wins
    serve(ADDI);
    c0 = iss_cnt;
    if_flush = 1; addr_to_if = 32'h200;
    cyc();
    if_flush = 0;
    chk("flush_iss_cnt", iss_cnt - c0, 1);
    wait_req("redir200", 32'h200);

    // taken branch
    serve(BEQ16);
    chk("br_ask", 32'(ask_predictor), 1);
    chk("br_jaddr", jump_addr_from_if, 32'h210);
    chk("br_naddr", next_addr_from_if, 32'h204);
    chk("br_jalr", 32'(now_ins_jalr), 0);
    predictor_sgn_rdy = 1; jump = 1;
    cyc();
    predictor_sgn_rdy = 0; jump = 0;
    #1;
    chk("br_ask_off", 32'(ask_predictor), 0);
    chk("br_valid", 32'(ins_valid), 1);
    chk("br_pj", 32'(ins_pred_jump), 1);
    chk("br_pc", ins_pc, 32'h200);
    wait_req("br_target", 32'h210);

    // predictor occupied for 5 cycles
    predictor_occupied = 1;
    serve(BEQ16);
    for (int i = 0; i < 5; i++) begin
      chk("occ_ask", 32'(ask_predictor), 0);
      cyc();
    end
    predictor_occupied = 0;
    #1;
    chk("occ_ask_on", 32'(ask_predictor), 1);
    chk("occ_jaddr", jump_addr_from_if, 32'h220);
    c0 = iss_cnt;
    predictor_sgn_rdy = 1; jump = 0;
    cyc();
    predictor_sgn_rdy = 0;
    chk("occ_valid", 32'(ins_valid), 1);
    chk("occ_pj", 32'(ins_pred_jump), 0);
    if_flush = 1; addr_to_if = 32'h300;
    cyc();
    if_flush = 0;
    chk("occ_single", iss_cnt - c0, 1);
    chk("occ_valid_off", 32'(ins_valid), 0);
    wait_req("redir300", 32'h300);

    // jal, no predictor involvement
    c0 = ask_cnt;
    serve(JALM8);
    chk("jal_valid", 32'(ins_valid), 1);
    chk("jal_pj", 32'(ins_pred_jump), 1);
    chk("jal_ask", 32'(ask_predictor), 0);
    wait_req("jal_target", 32'h2F8);
    chk("jal_ask_cnt", ask_cnt - c0, 0);

    // flush during WAIT_MEM -> drain
    c0 = iss_cnt;
    if_flush = 1; addr_to_if = 32'h400;
    cyc();
    if_flush = 0;
    chk("drain_req", 32'(icache_req), 1);
    cyc();
    serve(ADDI);
    chk("drain_req_off", 32'(icache_req), 0);
    chk("drain_valid", 32'(ins_valid), 0);
    wait_req("drain_target", 32'h400);
    chk("drain_no_iss", iss_cnt - c0, 0);

    // stall with rdy gaps
    issue_stall = 1;
    serve(ADDI);
    c0 = iss_cnt;
    for (int i = 0; i < 3; i++) begin
      rdy = (i != 1);
      chk("stall_valid", 32'(ins_valid), 1);
      chk("stall_pc", ins_pc, 32'h400);
      chk("stall_ins", ins, ADDI);
      cyc();
    end
    rdy = 1; issue_stall = 0;
    cyc();
    chk("stall_valid_off", 32'(ins_valid), 0);
    chk("stall_single", iss_cnt - c0, 1);
    wait_req("stall_next", 32'h404);

    // jalr bypasses occupied
    predictor_occupied = 1;
    serve(JALR);
    chk("jalr_ask", 32'(ask_predictor), 1);
    chk("jalr_flag", 32'(now_ins_jalr), 1);
    chk("jalr_jaddr", jump_addr_from_if, 0);
    chk("jalr_naddr", next_addr_from_if, 32'h408);
    predictor_sgn_rdy = 1; jump = 0;
    cyc();
    predictor_sgn_rdy = 0; predictor_occupied = 0;
    chk("jalr_valid", 32'(ins_valid), 1);
    chk("jalr_pj", 32'(ins_pred_jump), 0);
    wait_req("jalr_next", 32'h408);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
